// File: rtl/note_seq_pkg.sv
// Shared constants and state type for the note sequence reader.
package note_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DUR_W_DEF  = 8;

    // A zero duration word marks the end of the song in note RAM.
    localparam int unsigned END_MARKER = 0;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] FETCH_ENC = 2'd1;
    localparam logic [1:0] HOLD_ENC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        FETCH = FETCH_ENC,
        HOLD  = HOLD_ENC
    } state_e;

endpackage

// File: rtl/note_dur_counter.sv
// Per-note duration counter: loaded with the note length, counts down on beat ticks.
module note_dur_counter
    import note_seq_pkg::*;
#(
    parameter int unsigned DUR_W = DUR_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             tick,
    input  logic             hold,
    input  logic             clear,
    output logic             last,
    output logic [DUR_W-1:0] count
);

    logic [DUR_W-1:0] count_q;
    logic             step;

    // A held or already-expired counter ignores ticks.
    assign step  = tick && !hold && (count_q != '0);
    assign last  = step && (count_q == DUR_W'(1));
    assign count = count_q;

    // Count register: clear beats load beats decrement.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (step) begin
            count_q <= count_q - DUR_W'(1);
        end
    end

endmodule

// File: rtl/note_seq_reader.sv
// Note RAM read sequencer: walks addresses 0..limit, holding each note for its
// duration in beat ticks. Optional pause input/paused output with NOTE_SEQ_PAUSE_EN.
module note_seq_reader
    import note_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DUR_W  = DUR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              listen,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] limit,
    input  logic              tick,
    input  logic [DUR_W-1:0]  note_dur,
`ifdef NOTE_SEQ_PAUSE_EN
    input  logic              pause,
    output logic              paused,
`endif
    output logic [ADDR_W-1:0] readDirection,
    output logic              note_valid,
    output logic              playing,
    output logic              finish
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               nv_q, nv_d;
    logic               fin_q, fin_d;

    logic               cnt_load;
    logic               cnt_clear;
    logic               cnt_tick;
    logic               cnt_hold;
    logic               cnt_last;
    logic [DUR_W-1:0]   dur_cnt;
    logic               note_done;
    logic               end_rule;

    // Ticks only matter while a note is being held.
    assign cnt_tick = tick && (state_q == HOLD);

`ifdef NOTE_SEQ_PAUSE_EN
    assign cnt_hold = pause;
    assign paused   = pause && (state_q == HOLD);
`else
    assign cnt_hold = 1'b0;
`endif

    // An empty counter in HOLD can only follow an abnormal load; end the note
    // rather than stall forever.
    assign note_done = cnt_last || (dur_cnt == '0);

    note_dur_counter #(
        .DUR_W(DUR_W)
    ) u_dur_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (note_dur),
        .tick     (cnt_tick),
        .hold     (cnt_hold),
        .clear    (cnt_clear),
        .last     (cnt_last),
        .count    (dur_cnt)
    );

    // Next-state, address and strobe decode; listen > stop > play > sequencing.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        nv_d      = 1'b0;
        fin_d     = 1'b0;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        end_rule  = 1'b0;

        if (listen || stop) begin
            state_d   = IDLE;
            addr_d    = '0;
            cnt_clear = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    addr_d = '0;
                    if (play) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (note_dur == DUR_W'(END_MARKER)) begin
                        // A marker at address 0 would loop forever: always finish.
                        if (addr_q == '0) begin
                            fin_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            end_rule = 1'b1;
                        end
                    end else begin
                        cnt_load = 1'b1;
                        nv_d     = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_tick && !cnt_hold && note_done) begin
                        // >= also covers a limit lowered below the current address.
                        if (addr_q >= limit) begin
                            end_rule = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            endcase

            if (end_rule) begin
                addr_d = '0;
                if (loop_en) begin
                    state_d = FETCH;
                end else begin
                    fin_d   = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    // State, address and output strobe registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            nv_q    <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nv_q    <= nv_d;
            fin_q   <= fin_d;
        end
    end

    assign readDirection = addr_q;
    assign note_valid    = nv_q;
    assign finish        = fin_q;
    assign playing       = (state_q == FETCH) || (state_q == HOLD);

endmodule

// File: tb/tb_note_seq_reader.sv
// Self-checking bench for note_seq_reader against a note-level timeline model.
module tb_note_seq_reader;

    localparam int LMAX   = 256;
    localparam int NWORDS = 64;

    logic       clock = 1'b0;
    logic       reset;
    logic       listen, play, stop, loop_en, tick;
    logic [5:0] limit;
    logic [7:0] note_dur;
    logic [5:0] readDirection;
    logic       note_valid, playing, finish;
`ifdef NOTE_SEQ_PAUSE_EN
    logic       pause, paused;
`endif

    logic [7:0] ram [NWORDS];
    assign note_dur = ram[readDirection];

    int n_cmp = 0;
    int n_bad = 0;

    bit         tick_at [LMAX];
    bit         play_at [LMAX];
    bit         stop_at [LMAX];
    bit         listen_at [LMAX];
    logic [5:0] lim_at [LMAX];
    bit         exp_play [LMAX];
    bit         exp_nv [LMAX];
    bit         exp_fin [LMAX];
    logic [5:0] exp_addr [LMAX];
    bit         cur_loop;
    int         end1;

    always #5 clock = ~clock;

    note_seq_reader #(
        .ADDR_W(6),
        .DUR_W (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .listen        (listen),
        .play          (play),
        .stop          (stop),
        .loop_en       (loop_en),
        .limit         (limit),
        .tick          (tick),
        .note_dur      (note_dur),
`ifdef NOTE_SEQ_PAUSE_EN
        .pause         (pause),
        .paused        (paused),
`endif
        .readDirection (readDirection),
        .note_valid    (note_valid),
        .playing       (playing),
        .finish        (finish)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packed view {playing, note_valid, finish, address}.
    function automatic logic [31:0] pack(input logic p, input logic nv, input logic f,
                                         input logic [5:0] a);
        return {23'd0, p, nv, f, a};
    endfunction

    task automatic set_stim(input int len, input logic [5:0] lim, input bit lp);
        for (int c = 0; c < LMAX; c++) begin
            tick_at[c] = 0; play_at[c] = 0; stop_at[c] = 0; listen_at[c] = 0;
            lim_at[c] = lim;
        end
        play_at[0]     = 1;
        stop_at[len-3] = 1;
        cur_loop       = lp;
    endtask

    // Song timeline: play in cycle 0, one fetch cycle per note, note shown the cycle
    // after its fetch and held until its duration's worth of ticks has been seen.
    // Everything after the abort cycle `cut` is idle.
    task automatic build_model(input int len, input int cut);
        int  t, a, c, k;
        bit  done, ended;
        for (int i = 0; i < LMAX; i++) begin
            exp_play[i] = 0; exp_nv[i] = 0; exp_fin[i] = 0; exp_addr[i] = '0;
        end
        end1 = -1;
        t    = 1;
        a    = 0;
        done = 0;
        while (!done && t < len) begin
            exp_play[t] = 1;
            exp_addr[t] = 6'(a);
            if (ram[a] == 0) begin
                if (cur_loop && a != 0) begin
                    a = 0;
                    t++;
                end else begin
                    if (t + 1 < len) exp_fin[t+1] = 1;
                    done = 1;
                end
            end else begin
                c     = t + 1;
                k     = 0;
                ended = 0;
                while (c < len && !ended) begin
                    exp_play[c] = 1;
                    exp_addr[c] = 6'(a);
                    if (c == t + 1) exp_nv[c] = 1;
                    if (tick_at[c]) begin
                        k++;
                        if (k == int'(ram[a])) ended = 1;
                    end
                    if (!ended) c++;
                end
                if (!ended) begin
                    done = 1;
                end else begin
                    if (a == 1 && end1 < 0) end1 = c;
                    if (a >= int'(lim_at[c])) begin
                        if (cur_loop) begin
                            a = 0;
                        end else begin
                            if (c + 1 < len) exp_fin[c+1] = 1;
                            done = 1;
                        end
                    end else begin
                        a++;
                    end
                    t = c + 1;
                end
            end
        end
        for (int i = cut + 1; i < len; i++) begin
            exp_play[i] = 0; exp_nv[i] = 0; exp_fin[i] = 0; exp_addr[i] = '0;
        end
    endtask

    task automatic run(input int len, input string name);
        for (int c = 0; c < len; c++) begin
            @(posedge clock);
            #1;
            tick    = tick_at[c];
            play    = play_at[c];
            stop    = stop_at[c];
            listen  = listen_at[c];
            limit   = lim_at[c];
            loop_en = cur_loop;
            @(negedge clock);
            check($sformatf("%s c%0d", name, c),
                  pack(playing, note_valid, finish, readDirection),
                  pack(exp_play[c], exp_nv[c], exp_fin[c], exp_addr[c]));
        end
        @(posedge clock);
        #1;
        tick = 0; play = 0; stop = 0; listen = 0;
    endtask

    task automatic step(input bit t_v, input bit p_v, input bit pz_v);
        @(posedge clock);
        #1;
        tick = t_v;
        play = p_v;
`ifdef NOTE_SEQ_PAUSE_EN
        pause = pz_v;
`else
        if (pz_v) $display("pause request ignored in this build");
`endif
        @(negedge clock);
    endtask

    initial begin
        int  e, ticks;
        bit  found, seen;
        reset = 0; listen = 0; play = 0; stop = 0; loop_en = 0; tick = 0; limit = '0;
`ifdef NOTE_SEQ_PAUSE_EN
        pause = 0;
`endif
        for (int i = 0; i < NWORDS; i++) ram[i] = 8'd1;
        repeat (3) @(negedge clock);
        check("reset", pack(playing, note_valid, finish, readDirection), 32'd0);
        reset = 1;
        repeat (2) @(negedge clock);

        // Basic play {2,1,3}, limit 2, tick every 4 cycles.
        ram[0] = 8'd2; ram[1] = 8'd1; ram[2] = 8'd3; ram[3] = 8'd7;
        set_stim(60, 6'd2, 0);
        for (int c = 0; c < 60; c++) tick_at[c] = (c % 4 == 3);
        build_model(60, 57);
        run(60, "basic");

        // Loop mode, then stop.
        set_stim(110, 6'd2, 1);
        for (int c = 0; c < 110; c++) tick_at[c] = (c % 4 == 3);
        build_model(110, 107);
        run(110, "loop");

        // End marker at address 1.
        ram[0] = 8'd4; ram[1] = 8'd0; ram[2] = 8'd5;
        set_stim(60, 6'd2, 0);
        for (int c = 0; c < 60; c++) tick_at[c] = (c % 4 == 3);
        build_model(60, 57);
        run(60, "marker");

        // Full address range with limit at max: last address must end the song.
        for (int i = 0; i < NWORDS; i++) ram[i] = 8'd1;
        set_stim(200, 6'd63, 0);
        for (int c = 0; c < 200; c++) tick_at[c] = 1;
        build_model(200, 197);
        run(200, "limmax");

        // Single-note song.
        ram[0] = 8'd2;
        set_stim(30, 6'd0, 0);
        for (int c = 0; c < 30; c++) tick_at[c] = (c % 3 == 0);
        build_model(30, 27);
        run(30, "lim0");

        // listen on the last tick of address 1; play during listen is ignored.
        ram[0] = 8'd2; ram[1] = 8'd3;
        for (int i = 2; i < NWORDS; i++) ram[i] = 8'd2;
        set_stim(80, 6'd5, 0);
        for (int c = 0; c < 80; c++) tick_at[c] = (c % 3 == 2);
        build_model(80, 77);
        e = end1;
        if (e < 0 || e + 6 >= 77) begin
            check("abort_setup", 32'(e), 32'd14);
        end else begin
            for (int c = e; c <= e + 5; c++) listen_at[c] = 1;
            play_at[e+3] = 1;
            build_model(80, e);
            run(80, "abort");
        end

        // Randomized songs with live limit changes and ignored play pulses.
        for (int r = 0; r < 16; r++) begin
            int x;
            for (int i = 0; i < NWORDS; i++)
                ram[i] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'(($urandom_range(1, 4)));
            set_stim(150, (r == 5) ? 6'd63 : 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            x = $urandom_range(10, 140);
            if ($urandom_range(0, 1) == 1)
                for (int c = x; c < 150; c++) lim_at[c] = 6'($urandom_range(0, 7));
            for (int c = 0; c < 150; c++) tick_at[c] = ($urandom_range(0, 2) == 0);
            build_model(150, 147);
            for (int c = 1; c < 147; c++)
                if (exp_play[c] && $urandom_range(0, 7) == 0) play_at[c] = 1;
            run(150, $sformatf("rnd%0d", r));
        end

        // Asynchronous reset mid-HOLD at address 3.
        for (int i = 0; i < NWORDS; i++) ram[i] = 8'd3;
        limit = 6'd10; loop_en = 0;
        step(0, 1, 0);
        found = 0;
        seen  = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(i % 2 == 1, 0, 0);
            if (seen && readDirection == 6'd3 && playing && !note_valid) found = 1;
            if (note_valid && readDirection == 6'd3) seen = 1;
        end
        check("rst_reach", 32'(found), 32'd1);
        #2;
        reset = 0;
        #1;
        check("async_rst", pack(playing, note_valid, finish, readDirection), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1;
        step(0, 0, 0);
        set_stim(60, 6'd10, 0);
        for (int c = 0; c < 60; c++) tick_at[c] = (c % 2 == 1);
        build_model(60, 57);
        run(60, "restart");

`ifdef NOTE_SEQ_PAUSE_EN
        // Pause for 10 ticks inside a 3-tick note, then 2 ticks remain.
        ram[0] = 8'd3;
        limit = 6'd0; loop_en = 0;
        check("paused_idle", 32'(paused), 32'd0);
        step(0, 1, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 0, 0);
            if (note_valid) found = 1;
        end
        check("pause_nv", 32'(found), 32'd1);
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(i % 2 == 0, 0, 1);
            if (i == 0 || i == 19)
                check($sformatf("pause_hold%0d", i), {29'd0, paused, playing, readDirection == 6'd0},
                      32'd7);
        end
        ticks = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(i % 2 == 0, 0, 0);
            if (finish) found = 1;
            else if (i % 2 == 0) ticks++;
        end
        check("pause_end", 32'(found), 32'd1);
        check("pause_ticks", 32'(ticks), 32'd2);
        check("paused_done", 32'(paused), 32'd0);
        step(0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/note_seq_reader.md
Name: note_seq_reader

Overview:
- Parametrised successor to the note-memory read-address counter.
- Walks a synchronous note RAM from address 0 to `limit` and holds each note for a per-note duration counted in beat ticks.
- Supports loop mode, stop/abort, and an end-of-song marker.
- Sits between the note RAM and the tone synthesiser; `listen` (record mode) overrides playback.

Parameters:
- ADDR_W, 6, width of the note RAM address and of `limit`.
- DUR_W, 8, width of the duration field read from the note RAM.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- listen  in  1  record mode; level; aborts playback and clears state.
- play  in  1  start request; 1-cycle pulse.
- stop  in  1  abort request; 1-cycle pulse.
- loop_en  in  1  level; on the last note, wrap to address 0 instead of finishing.
- limit  in  ADDR_W  last valid address, inclusive; sampled live.
- tick  in  1  beat-tick enable, 1-cycle strobe.
- note_dur  in  DUR_W  duration field of the RAM word at `readDirection`; valid 1 cycle after the address changes.
- readDirection  out  ADDR_W  note RAM read address.
- note_valid  out  1  1-cycle strobe: a new note is presented to the synth.
- playing  out  1  high in FETCH and HOLD.
- finish  out  1  1-cycle pulse at normal end of song.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; `readDirection`=0, `note_valid`=0, `playing`=0, `finish`=0, dur_cnt=0.
- Control priority each cycle: `listen` > `stop` > `play` > sequencing.
- `listen`=1 or `stop`=1 in any state: next state IDLE, `readDirection`=0, `finish`=0, `note_valid`=0.
- States are IDLE, FETCH, HOLD.
- IDLE:
  - `readDirection`=0.
  - `play`=1 -> FETCH.
  - `tick` is ignored.
- FETCH (exactly 1 cycle, covers RAM latency). On exit, sample `note_dur`:
  - `note_dur`==0 is the end marker, treated as end of song (see end rule); no `note_valid`.
  - Otherwise dur_cnt=`note_dur`, `note_valid`=1 for one cycle, -> HOLD.
- HOLD:
  - On `tick`, dur_cnt decrements.
  - On `tick` with dur_cnt==1, the note ends: if `readDirection`>=`limit`, apply the end rule; otherwise `readDirection`+1 -> FETCH.
  - `tick` is only honoured in HOLD.
- End rule:
  - `loop_en`=1: `readDirection`=0 -> FETCH, no `finish`.
  - `loop_en`=0: `finish`=1 for one cycle, `readDirection`=0 -> IDLE.
- Note latency: `play` at cycle N -> address 0 driven at N+1 -> `note_valid` at N+2.
- `play` while `playing`=1 is ignored (no restart).
- Limit handling:
  - `limit`=0 is a single-note song.
  - `limit` lowered below `readDirection` mid-song: the song ends when the current note ends.
- Address arithmetic is unsigned, ADDR_W bits. Address 2^ADDR_W-1 with `limit` at max triggers the end rule, never a silent wrap.
- End marker with `loop_en`=1 at address 0 would spin forever; instead, `finish`=1 and -> IDLE.
- `finish` and `note_valid` are never high in the same cycle.

Optional Feature:
- Macro: NOTE_SEQ_PAUSE_EN.
- With the macro:
  - Adds input port `pause` (1 bit, level) and output port `paused` (1 bit).
  - While `pause`=1 in HOLD, `tick` is ignored; dur_cnt and `readDirection` are frozen; `playing` stays 1 and `paused`=1.
  - `pause` has no effect in IDLE or FETCH; `paused`=0 there.
  - `stop` and `listen` still override.
  - `paused` resets to 0.
- Without the macro: neither port exists; behaviour is as above.

Decomposition:
- Package `note_seq_pkg`:
  - State encoding localparams: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2.
  - END_MARKER constant = 0.
  - Default widths ADDR_W_DEF=6, DUR_W_DEF=8.
- Sub-module `note_dur_counter` (parametrised DUR_W):
  - Inputs: load, load value, tick, hold/pause, clear.
  - Outputs: `last` (dur_cnt==1 and tick) and the count.
- The FSM and address counter stay in the top level.

Test Plan:
- Basic play: RAM durations {2,1,3}, `limit`=2, `loop_en`=0, `tick` every 4 cycles, `play` pulse -> `note_valid` at addresses 0,1,2, held 2/1/3 ticks; then `finish` 1-cycle pulse; `readDirection`=0; `playing`=0.
- Loop mode: same RAM, `loop_en`=1 -> after address 2 ends, `readDirection`=0 and `note_valid` again; no `finish` for 3 loops. Then `stop` -> IDLE, `playing`=0, no `finish`.
- End marker: RAM {4,0,5}, `limit`=2 -> address 0 held 4 ticks; at address 1 `finish` pulses with no `note_valid`; address 2 is never played.
- Abort: `listen`=1 while in HOLD at address 1, asserted in the same cycle as `tick` and the last duration count -> next cycle IDLE, `readDirection`=0, no `finish`, no `note_valid`. `play` while `listen`=1 is ignored.
- Async reset: drive reset low mid-HOLD at address 3, between clock edges -> all outputs 0 immediately. Deassert, then `play` -> song restarts at address 0.
- NOTE_SEQ_PAUSE_EN build: `pause`=1 for 10 ticks during a 3-tick note -> `paused`=1, address frozen. Release -> note ends after exactly the remaining ticks.
